// File: rtl/eq_pkg.sv
// Shared types and constants for the equality lock monitor slice.
package eq_pkg;

    localparam int EQ_NIB_W     = 4;
    localparam int EQ_CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        LOCKED = 2'd1,
        LOST   = 2'd2
    } eq_lock_state_t;

    typedef struct packed {
        logic                    match;
        logic                    xflag;
        logic [EQ_CNT_W_DEF-1:0] run;
    } eq_result_t;

endpackage

// File: rtl/eq_lock_monitor_core.sv
// Nibble equality core: 4-state case equality plus an X/Z indicator.
module eq_lock_monitor_core
    import eq_pkg::*;
(
    input  logic [EQ_NIB_W-1:0] a,
    input  logic [EQ_NIB_W-1:0] b,
    output logic                match,
    output logic                xflag
);

    // xflag only differs from 0 in 4-state simulation; synthesis folds it away.
    assign match = (a === b);
    assign xflag = match && ((a == b) !== 1'b1);

endmodule

// File: rtl/eq_lock_monitor.sv
// Streaming equality monitor: run-length tracking, lock FSM and error counter.
module eq_lock_monitor
    import eq_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [EQ_NIB_W-1:0] in_a,
    input  logic [EQ_NIB_W-1:0] in_b,
    input  logic                clr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_match,
    output logic                out_xflag,
    output logic [CNT_W-1:0]    out_run,
    output logic                locked,
    output logic                lost_pulse,
    output logic [CNT_W-1:0]    err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LOCK_THR = CNT_W'(LOCK_CNT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    logic             match_s, xflag_s, accept_s;
    logic [CNT_W-1:0] run_r, run_next_s, out_run_r, err_cnt_r;
    logic             out_valid_r, out_match_r, out_xflag_r;
    logic             locked_r, lost_pulse_r, locked_next_s, lost_next_s;
    eq_lock_state_t   state_r, state_next_s;

    eq_lock_monitor_core u_core (
        .a     (in_a),
        .b     (in_b),
        .match (match_s),
        .xflag (xflag_s)
    );

    assign in_ready = !out_valid_r || out_ready;
    assign accept_s = in_valid && in_ready;

    // Run length this beat would carry.
    always_comb begin
        run_next_s = '0;
        if (match_s) begin
            run_next_s = sat_inc(run_r);
        end else begin
            run_next_s = '0;
        end
    end

    // Lock FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= HUNT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Lock FSM next state; moves only on accepted beats.
    always_comb begin
        state_next_s = state_r;
        if (accept_s) begin
            case (state_r)
                HUNT:    state_next_s = (run_next_s >= LOCK_THR) ? LOCKED : HUNT;
                LOCKED:  state_next_s = match_s ? LOCKED : LOST;
                LOST:    state_next_s = match_s ? LOCKED : HUNT;
                default: state_next_s = HUNT;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Lock FSM outputs, registered below so they align with the result beat.
    always_comb begin
        locked_next_s = (state_next_s == LOCKED);
        lost_next_s   = 1'b0;
        if (accept_s && (state_r == LOCKED) && !match_s) begin
            lost_next_s = 1'b1;
        end else begin
            lost_next_s = 1'b0;
        end
    end

    // Result register, run tracker and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_match_r  <= 1'b0;
            out_xflag_r  <= 1'b0;
            out_run_r    <= '0;
            run_r        <= '0;
            locked_r     <= 1'b0;
            lost_pulse_r <= 1'b0;
        end else begin
            locked_r     <= locked_next_s;
            lost_pulse_r <= lost_next_s;
            if (accept_s) begin
                out_valid_r <= 1'b1;
                out_match_r <= match_s;
                out_xflag_r <= xflag_s;
                out_run_r   <= run_next_s;
                run_r       <= run_next_s;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    // Saturating mismatch counter; clr overrides a coincident increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_r <= '0;
        end else if (clr) begin
            err_cnt_r <= '0;
        end else if (accept_s && !match_s) begin
            err_cnt_r <= sat_inc(err_cnt_r);
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_match  = out_match_r;
    assign out_xflag  = out_xflag_r;
    assign out_run    = out_run_r;
    assign locked     = locked_r;
    assign lost_pulse = lost_pulse_r;
    assign err_cnt    = err_cnt_r;

endmodule

// File: doc/eq_lock_monitor.md
Name: eq_lock_monitor

Overview:
- Sequential stage directly downstream of the nibble equality comparator. Consumes a valid/ready stream of 4-bit (a, b) pairs and evaluates each pair.
- Evaluates both logical equality (2-state) and case equality (4-state). Tracks the consecutive-match run length and runs a lock FSM that declares lock after LOCK_CNT consecutive matches.
- Emits one registered result beat per accepted pair plus sticky status and a saturating mismatch counter for the link checker.

Parameters:
- LOCK_CNT, 4, consecutive matches required to enter LOCKED; legal range 1..2**CNT_W-1.
- CNT_W, 8, width of run-length and mismatch counters.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  pair present on in_a/in_b.
- in_ready  output  1  block can accept a pair this cycle.
- in_a  input  4  first nibble.
- in_b  input  4  second nibble.
- clr  input  1  synchronous clear of err_cnt only.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts result beat.
- out_match  output  1  pair was case-equal.
- out_xflag  output  1  case-equal but logical compare not 1 (X/Z seen; simulation only, constant 0 in synthesis).
- out_run  output  CNT_W  run length including this beat.
- locked  output  1  FSM in LOCKED.
- lost_pulse  output  1  one-cycle pulse on LOCKED->LOST.
- err_cnt  output  CNT_W  saturating count of mismatching beats.

Behaviour:
- Reset (async assert, sync deassert by upstream): out_valid=0, out_match=0, out_xflag=0, out_run=0, locked=0, lost_pulse=0, err_cnt=0, FSM=HUNT, internal run=0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; single output register, no skid).
  - Accept occurs when in_valid && in_ready.
  - out_valid holds with stable payload until out_ready.
  - in_valid may drop without an accept; in_a/in_b are not sampled then.
- Latency: 1 cycle. A pair accepted in cycle N is presented on out_* in cycle N+1. Back-to-back throughput is 1 beat/cycle while out_ready=1.
- Per accepted beat:
  - match = (in_a === in_b).
  - xflag = match && ((in_a == in_b) !== 1).
  - run_next = match ? sat_inc(run) : 0. Saturation at 2**CNT_W-1.
  - out_run = run_next.
  - Mismatch: err_cnt saturating increment.
- clr: err_cnt <= 0 in that cycle. If clr coincides with a mismatch accept, the result is 0; clr wins.
- FSM, evaluated only on accepted beats; no transition on idle cycles:
  - HUNT: run_next >= LOCK_CNT -> LOCKED; else stay.
  - LOCKED: mismatch -> LOST, lost_pulse=1 next cycle; match -> stay.
  - LOST: match -> LOCKED (single-error tolerance; run restarts from 1); mismatch -> HUNT.
- Status timing:
  - locked is registered and updates in the same cycle out_valid rises for the triggering beat.
  - lost_pulse lasts exactly one clock regardless of out_ready.
- Backpressure: while out_valid=1 && out_ready=0, no accept, no counter or FSM change.
- Reset mid-stream: any pending result beat is discarded and the run is lost. No beat is emitted after reset until a new accept.

Decomposition:
- Shared package eq_pkg holds:
  - typedef enum logic [1:0] {HUNT, LOCKED, LOST} eq_lock_state_t;
  - typedef struct packed {match, xflag, run} eq_result_t, parameterised via CNT_W constant EQ_CNT_W_DEF=8;
  - localparam EQ_NIB_W=4.
- One sub-module is natural: equality core computing match/xflag from a/b. Reuse the existing comparator as that core and do not duplicate it.

Test Plan:
- Reset, then pairs (3,3)x4 with out_ready=1 -> out_run 1,2,3,4; locked rises with the 4th result beat; err_cnt=0.
- Locked, then (5,6) then (7,7) -> out_match 0 then 1; lost_pulse for one cycle; FSM LOCKED->LOST->LOCKED; out_run 0 then 1; err_cnt=1.
- Locked, then (1,2),(1,2) -> FSM LOST then HUNT; locked=0; err_cnt=2.
- Result pending and out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0; out_* stable; no counter/FSM change; the next pair is accepted the cycle out_ready rises.
- CNT_W=4: 20 matches -> out_run saturates at 15. 20 mismatches -> err_cnt saturates at 15. clr during a mismatch accept -> err_cnt=0.
- Simulation: in_a=4'b10x1, in_b=4'b10x1 -> out_match=1, out_xflag=1. Then assert rst mid-beat with out_valid=1 -> out_valid=0 immediately; all outputs at reset values.
